// File: rtl/chacha_state_gen.sv
// chacha_state_gen
//   Builds ChaCha initial states (constants | key | counter | nonce) for a run
//   of keystream blocks and streams them out over a valid/ready handshake,
//   incrementing the block counter after every accepted state.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request pulse, accepted only when idle
//   key, nonce          byte strings, byte 0 in the most significant byte
//   counter_init        counter value for the first block
//   num_blocks          number of states to emit (0 = none)
//   busy                high while a request is in progress
//   state_valid/_ready  output handshake
//   state_out           16 x 32-bit words, word i at [32*i +: 32]
//   block_idx           0-based index of the state on state_out
//   done                one-cycle pulse at the end of a request
//   ctr_overflow        sticky: request stopped because the counter would wrap
module chacha_state_gen #(
    parameter int WIDTH       = 32,
    parameter int KEY_WIDTH   = 256,
    parameter int NONCE_WIDTH = 96,
    parameter int OUT_WIDTH   = 512,
    parameter int BLK_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KEY_WIDTH-1:0]       key,
    input  logic [NONCE_WIDTH-1:0]     nonce,
    input  logic [128-NONCE_WIDTH-1:0] counter_init,
    input  logic [BLK_WIDTH-1:0]       num_blocks,
    output logic                       busy,
    output logic                       state_valid,
    input  logic                       state_ready,
    output logic [OUT_WIDTH-1:0]       state_out,
    output logic [BLK_WIDTH-1:0]       block_idx,
    output logic                       done,
    output logic                       ctr_overflow
);

    localparam int CTR_WIDTH   = 128 - NONCE_WIDTH;
    localparam int CTR_WORDS   = CTR_WIDTH / 32;
    localparam int NONCE_WORDS = NONCE_WIDTH / 32;

    generate
        if (WIDTH != 32) begin : g_bad_width
            $error("chacha_state_gen: WIDTH must be 32");
        end
        if (KEY_WIDTH != 256 && KEY_WIDTH != 128) begin : g_bad_key
            $error("chacha_state_gen: KEY_WIDTH must be 256 or 128");
        end
        if (NONCE_WIDTH != 96 && NONCE_WIDTH != 64) begin : g_bad_nonce
            $error("chacha_state_gen: NONCE_WIDTH must be 96 or 64");
        end
        if (OUT_WIDTH != 16 * WIDTH) begin : g_bad_out
            $error("chacha_state_gen: OUT_WIDTH must equal 16*WIDTH");
        end
        if (BLK_WIDTH < 1) begin : g_bad_blk
            $error("chacha_state_gen: BLK_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_t;

    // Assemble one ChaCha initial state. Byte strings are big-endian in the
    // port vectors while ChaCha words are little-endian, hence the per-byte
    // placement. A 128-bit key is repeated into words 8-11.
    function automatic logic [OUT_WIDTH-1:0] build_state(
        input logic [KEY_WIDTH-1:0]   k,
        input logic [NONCE_WIDTH-1:0] n,
        input logic [CTR_WIDTH-1:0]   c
    );
        logic [OUT_WIDTH-1:0] s;
        int unsigned          kw;
        s = '0;
        s[0*32 +: 32] = 32'h61707865;
        s[1*32 +: 32] = (KEY_WIDTH == 256) ? 32'h3320646e : 32'h3120646e;
        s[2*32 +: 32] = (KEY_WIDTH == 256) ? 32'h79622d32 : 32'h79622d36;
        s[3*32 +: 32] = 32'h6b206574;
        for (int unsigned i = 0; i < 8; i++) begin
            kw = (KEY_WIDTH == 256) ? i : (i % 4);
            for (int unsigned j = 0; j < 4; j++) begin
                s[32*(4+i) + 8*j +: 8] = k[KEY_WIDTH-1-8*(4*kw+j) -: 8];
            end
        end
        for (int unsigned i = 0; i < CTR_WORDS; i++) begin
            s[32*(12+i) +: 32] = c[32*i +: 32];
        end
        for (int unsigned i = 0; i < NONCE_WORDS; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                s[32*(12+CTR_WORDS+i) + 8*j +: 8] = n[NONCE_WIDTH-1-8*(4*i+j) -: 8];
            end
        end
        return s;
    endfunction

    state_t                 fsm_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [NONCE_WIDTH-1:0] nonce_q;
    logic [CTR_WIDTH-1:0]   ctr_q;
    logic [BLK_WIDTH-1:0]   nblk_q;
    logic [BLK_WIDTH-1:0]   blk_q;
    logic [OUT_WIDTH-1:0]   state_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;

    logic [CTR_WIDTH-1:0]   ctr_d;
    logic [OUT_WIDTH-1:0]   next_state_d;
    logic [OUT_WIDTH-1:0]   first_state_d;
    logic                   last_blk;
    logic                   ctr_max;

    always_comb begin
        ctr_d         = ctr_q + CTR_WIDTH'(1);
        next_state_d  = build_state(key_q, nonce_q, ctr_d);
        first_state_d = build_state(key, nonce, counter_init);
        last_blk      = (blk_q == nblk_q - BLK_WIDTH'(1));
        ctr_max       = (ctr_q == '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            key_q   <= '0;
            nonce_q <= '0;
            ctr_q   <= '0;
            nblk_q  <= '0;
            blk_q   <= '0;
            state_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        key_q   <= key;
                        nonce_q <= nonce;
                        ctr_q   <= counter_init;
                        nblk_q  <= num_blocks;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (num_blocks == '0) begin
                            fsm_q <= FIN;
                        end else begin
                            state_q <= first_state_d;
                            blk_q   <= '0;
                            valid_q <= 1'b1;
                            fsm_q   <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (valid_q && state_ready) begin
                        if (last_blk) begin
                            valid_q <= 1'b0;
                            fsm_q   <= FIN;
                        end else if (ctr_max) begin
                            // Stop before the counter wraps; the wrapped value is never emitted.
                            ovf_q   <= 1'b1;
                            valid_q <= 1'b0;
                            fsm_q   <= FIN;
                        end else begin
                            ctr_q   <= ctr_d;
                            blk_q   <= blk_q + BLK_WIDTH'(1);
                            state_q <= next_state_d;
                        end
                    end
                end
                FIN: begin
                    // done is registered from FIN, so it appears as busy drops.
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
                default: begin
                    fsm_q   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign state_valid  = valid_q;
    assign state_out    = state_q;
    assign block_idx    = blk_q;
    assign done         = done_q;
    assign ctr_overflow = ovf_q;

endmodule

// File: tb/tb_chacha_state_gen.sv
// tb_chacha_state_gen
//   Directed test of chacha_state_gen: one instance with default parameters
//   (256-bit key, 96-bit nonce) and one with a 128-bit key and 64-bit counter.
module tb_chacha_state_gen;

    logic         clk = 1'b0;
    logic         reset;
    always #5 clk = ~clk;

    // default-parameter instance
    logic         start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [15:0]  nb;
    logic         ready;
    logic         busy, valid, done, ovf;
    logic [511:0] sout;
    logic [15:0]  bidx;

    // 128-bit key / 64-bit counter instance
    logic         start_b;
    logic [127:0] key_b;
    logic [63:0]  nonce_b;
    logic [63:0]  ctr_b;
    logic [15:0]  nb_b;
    logic         ready_b;
    logic         busy_b, valid_b, done_b, ovf_b;
    logic [511:0] sout_b;
    logic [15:0]  bidx_b;

    chacha_state_gen dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .nonce(nonce),
        .counter_init(ctr), .num_blocks(nb), .busy(busy), .state_valid(valid),
        .state_ready(ready), .state_out(sout), .block_idx(bidx), .done(done),
        .ctr_overflow(ovf)
    );

    chacha_state_gen #(.KEY_WIDTH(128), .NONCE_WIDTH(64)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .key(key_b), .nonce(nonce_b),
        .counter_init(ctr_b), .num_blocks(nb_b), .busy(busy_b), .state_valid(valid_b),
        .state_ready(ready_b), .state_out(sout_b), .block_idx(bidx_b), .done(done_b),
        .ctr_overflow(ovf_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a request on the default instance and check the first-cycle response.
    task automatic go(input logic [15:0] nb_v, input logic [31:0] ctr_v);
        nb    = nb_v;
        ctr   = ctr_v;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("first_valid", valid, (nb_v != 0));
        chk("busy_after_start", busy, 1);
    endtask

    // Drive state_ready (always 1, or 1,0,0 repeating), check each accepted
    // state's counter word and index, check holding under backpressure, and
    // stop at the done pulse or after a bounded number of cycles.
    task automatic stream(input logic [31:0] c0, input bit bp, input bit poke,
                          output int hs, output int dn);
        logic [511:0] held_s;
        logic [15:0]  held_i;
        bit           hold;
        hs   = 0;
        dn   = 0;
        hold = 0;
        for (int cyc = 0; cyc < 60 && dn == 0; cyc++) begin
            if (done) begin
                dn = 1;
            end else begin
                if (hold) begin
                    chk("stable_state", sout, held_s);
                    chk("stable_idx", bidx, held_i);
                    chk("stable_valid", valid, 1);
                end
                ready = bp ? (cyc % 3 == 0) : 1'b1;
                if (poke && cyc == 1) begin
                    start = 1'b1;
                    nb    = 16'd7;
                    ctr   = 32'd100;
                end else begin
                    start = 1'b0;
                end
                hold   = valid && !ready;
                held_s = sout;
                held_i = bidx;
                if (valid && ready) begin
                    chk("word12", sout[12*32 +: 32], c0 + hs);
                    chk("block_idx", bidx, hs);
                    hs++;
                end
                tick;
            end
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    // Finish a request: done seen, handshake count, done lasts one cycle, idle after.
    task automatic finish_req(input string tag, input int hs, input int dn, input int exp_hs);
        chk({tag, "_done"}, dn, 1);
        chk({tag, "_handshakes"}, hs, exp_hs);
        chk({tag, "_valid_at_done"}, valid, 0);
        chk({tag, "_busy_at_done"}, busy, 0);
        tick;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    localparam logic [511:0] RFC_STATE = {
        32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
        32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    localparam logic [511:0] B_STATE1 = {
        32'h08070605, 32'h04030201, 32'h00000000, 32'hffffffff,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

    localparam logic [511:0] B_STATE2 = {
        32'h08070605, 32'h04030201, 32'h00000001, 32'h00000000,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

    int hs, dn;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        key     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        nonce   = 96'h000000090000004a00000000;
        ctr     = '0;
        nb      = '0;
        ready   = 1'b1;
        start_b = 1'b0;
        key_b   = 128'h000102030405060708090a0b0c0d0e0f;
        nonce_b = 64'h0102030405060708;
        ctr_b   = 64'h00000000ffffffff;
        nb_b    = 16'd2;
        ready_b = 1'b1;
        tick;
        tick;
        reset = 1'b0;

        // reset state
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", sout, 0);
        chk("rst_idx", bidx, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);

        // RFC 8439 2.3.2 vector
        go(16'd1, 32'd1);
        chk("rfc_state", sout, RFC_STATE);
        chk("rfc_idx", bidx, 0);
        stream(32'd1, 0, 0, hs, dn);
        finish_req("rfc", hs, dn, 1);

        // streaming with backpressure
        go(16'd4, 32'd5);
        stream(32'd5, 1, 0, hs, dn);
        finish_req("bp", hs, dn, 4);

        // 128-bit key, 64-bit counter crossing the 32-bit boundary
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("k128_valid1", valid_b, 1);
        chk("k128_state1", sout_b, B_STATE1);
        tick;
        chk("k128_valid2", valid_b, 1);
        chk("k128_state2", sout_b, B_STATE2);
        chk("k128_idx2", bidx_b, 1);
        tick;
        chk("k128_fin_valid", valid_b, 0);
        tick;
        chk("k128_done", done_b, 1);
        chk("k128_ovf", ovf_b, 0);

        // counter wrap
        go(16'd5, 32'hfffffffe);
        stream(32'hfffffffe, 0, 0, hs, dn);
        chk("wrap_ovf", ovf, 1);
        finish_req("wrap", hs, dn, 2);
        chk("wrap_ovf_sticky", ovf, 1);
        go(16'd1, 32'd0);
        chk("wrap_ovf_clear", ovf, 0);
        stream(32'd0, 0, 0, hs, dn);
        finish_req("after_wrap", hs, dn, 1);

        // zero blocks: no state, done two cycles after start
        go(16'd0, 32'd9);
        chk("zero_fin_done", done, 0);
        tick;
        chk("zero_done", done, 1);
        chk("zero_valid", valid, 0);
        chk("zero_busy", busy, 0);
        tick;
        chk("zero_done_pulse", done, 0);

        // start during EMIT is ignored
        go(16'd3, 32'd20);
        stream(32'd20, 1, 1, hs, dn);
        finish_req("ignore", hs, dn, 3);

        // reset mid-stream
        go(16'd4, 32'd10);
        tick;
        tick;
        chk("mid_idx", bidx, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_state", sout, 0);
        chk("mid_rst_idx", bidx, 0);
        chk("mid_rst_done", done, 0);
        tick;
        chk("mid_rst_no_done", done, 0);
        go(16'd1, 32'd1);
        chk("post_rst_state", sout, RFC_STATE);
        stream(32'd1, 0, 0, hs, dn);
        finish_req("post_rst", hs, dn, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_state_gen.md
Name: chacha_state_gen

Overview:
Parametrised successor to the ChaCha20 initial-state builder. It latches key, nonce, initial counter and a block count on a start request. It then streams one 512-bit ChaCha initial state per keystream block over a valid/ready interface, auto-incrementing the block counter. It supports 128/256-bit keys and 32/64-bit counters, and feeds the ChaCha round core in the message-authentication datapath.

Parameters:
WIDTH, 32, state word width; fixed at 32, any other value is illegal.
KEY_WIDTH, 256, key size; 256 or 128.
NONCE_WIDTH, 96, nonce size; 96 (IETF, 32-bit counter) or 64 (original, 64-bit counter).
OUT_WIDTH, 512, state width; must equal 16*WIDTH.
BLK_WIDTH, 16, width of the num_blocks request field.
CTR_WIDTH is local and equals 128-NONCE_WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request pulse; accepted only in IDLE.
key  in  KEY_WIDTH  key as a byte string; byte 0 sits in bits [KEY_WIDTH-1 -: 8].
nonce  in  NONCE_WIDTH  nonce as a byte string; byte 0 sits in the MSB byte.
counter_init  in  CTR_WIDTH  counter value for the first block.
num_blocks  in  BLK_WIDTH  number of states to emit.
busy  out  1  high outside IDLE.
state_valid  out  1  state_out holds a valid state.
state_ready  in  1  consumer accepts the state.
state_out  out  OUT_WIDTH  word i is at [32*i +: 32].
block_idx  out  BLK_WIDTH  index of the current state, 0-based.
done  out  1  one-cycle pulse at the end of a request.
ctr_overflow  out  1  sticky counter-wrap error.

Behaviour:
- Reset (synchronous, any state):
  - FSM goes to IDLE.
  - state_valid, busy, done, ctr_overflow = 0.
  - state_out = 0 and block_idx = 0.
  - Reset mid-stream abandons the request.
- FSM states: IDLE, EMIT, FIN.
- IDLE, on start:
  - Latch all inputs and clear ctr_overflow.
  - If num_blocks==0: go to FIN, and emit no state.
  - Otherwise: build the state with counter_init, go to EMIT, set state_valid=1 and block_idx=0.
  - First state is valid exactly 1 cycle after start.
- start is ignored while busy. Inputs are sampled only at acceptance, so later input changes have no effect.
- EMIT holds state_out, state_valid and block_idx stable while state_valid && !state_ready.
- Handshake (state_valid && state_ready) at edge n:
  - If this was the last block (block_idx==num_blocks-1): state_valid=0 and go to FIN.
  - Else if counter==all-ones: set ctr_overflow=1, state_valid=0 and go to FIN. The wrapped counter is never emitted.
  - Else: counter+1 and block_idx+1, with the new state valid at edge n+1. Throughput is 1 state/cycle with state_ready held high.
- FIN: done=1 for one cycle, then IDLE with busy=0. A start in the FIN cycle is ignored.
- ctr_overflow persists until the next accepted start or reset.
- State layout, where lw() is the little-endian word of 4 consecutive bytes:
  - Words 0-3, constants:
    - 256-bit key ("expand 32-byte k"): 61707865, 3320646e, 79622d32, 6b206574.
    - 128-bit key ("expand 16-byte k"): 61707865, 3120646e, 79622d36, 6b206574.
  - Words 4-11, key:
    - 256-bit key: lw(key bytes 4i..4i+3) for i=0..7.
    - 128-bit key: words 4-7 = words 8-11 = lw(key bytes 0..15).
  - Words 12-15, counter and nonce:
    - NONCE_WIDTH=96: word12 = counter; words 13-15 = lw(nonce bytes 0-3, 4-7, 8-11).
    - NONCE_WIDTH=64: word12 = counter[31:0]; word13 = counter[63:32]; words 14-15 = lw(nonce bytes 0-3, 4-7).
- Counter arithmetic is modulo 2^CTR_WIDTH, with the wrap detected as above. block_idx is BLK_WIDTH bits and never wraps, because it is bounded by num_blocks.
- Illegal parameter values must fail elaboration.

Test Plan:
- RFC 8439 2.3.2 vector (defaults):
  - Stimulus: key=000102..1f, nonce=000000090000004a00000000, counter_init=1, num_blocks=1, state_ready=1.
  - Required response: 1 cycle after start, state_valid=1 with words 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000. done pulses the cycle after the handshake.
- Streaming with backpressure:
  - Stimulus: num_blocks=4, counter_init=5, state_ready toggling 1,0,0,1,...
  - Required response: states carry word12 = 5,6,7,8 with block_idx 0-3. state_out is stable during ready=0. Exactly 4 handshakes, then a single done pulse.
- 128-bit key with 64-bit counter:
  - Stimulus: KEY_WIDTH=128, NONCE_WIDTH=64, counter_init=0000_0000_ffff_ffff, num_blocks=2.
  - Required response: word1=3120646e and word2=79622d36. words 4-7 equal words 8-11. Second state has word12=00000000 and word13=00000001.
- Counter wrap:
  - Stimulus: defaults, counter_init=ffff_fffe, num_blocks=5.
  - Required response: exactly 2 states are emitted (fffffffe, ffffffff), then ctr_overflow=1 and done pulses. ctr_overflow clears on the next start.
- Zero blocks and ignored start:
  - Stimulus: num_blocks=0, then a start asserted during EMIT of a 3-block request.
  - Required response: the first case gives no state_valid and done 2 cycles after start. In the second case, the mid-request start has no effect and exactly 3 states are emitted.
- Reset mid-stream:
  - Stimulus: assert reset during block 2 of 4.
  - Required response: the next edge gives state_valid=0, busy=0, state_out=0, block_idx=0 and no done. A new start then works normally.
